// File: rtl/mem_uart_tx.sv
// Memory-mapped UART transmitter: DATA/STATUS registers, byte FIFO and an 8N1 serializer.
// Defining UART_TX_PARITY_EN adds an even-parity bit after the data bits (8E1).
module mem_uart_tx #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [3:0]  mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        txd
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [15:0]   DIV_M1  = 16'(CLK_DIV - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    function automatic logic parity8(input logic [7:0] b);
        return ^b;
    endfunction
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3
    } state_t;
`endif

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_s, empty_s, push_s, pop_s;
    logic [7:0]    fifo_rdata_s;

    logic          ready_q, ready_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          is_wr_s, sel_data_s, sel_stat_s, push_req_s, stall_s, accept_s;
    logic [31:0]   status_s;

    state_t        state_q, state_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          txd_q, txd_d;
    logic          busy_s, baud_end_s;
`ifdef UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    logic          unused_s;
    assign unused_s = ^mem_wdata[31:8];

    assign full_s       = (count_q == DEPTH_C);
    assign empty_s      = (count_q == '0);
    assign fifo_rdata_s = fifo_mem[rd_ptr_q];
    assign busy_s       = (state_q != S_IDLE);
    assign baud_end_s   = (baud_q == DIV_M1);

    // A full FIFO still takes a write in the same cycle the serializer pops.
    assign is_wr_s    = |mem_wstrb;
    assign sel_data_s = (mem_addr == 4'h0);
    assign sel_stat_s = (mem_addr == 4'h4);
    assign push_req_s = mem_valid && !ready_q && is_wr_s && sel_data_s && mem_wstrb[0];
    assign stall_s    = push_req_s && full_s && !pop_s;
    assign accept_s   = mem_valid && !ready_q && !stall_s;
    assign push_s     = push_req_s && !stall_s;
    assign status_s   = {16'h0000, 8'(count_q), 5'b00000, empty_s, full_s, busy_s};

    // Bus response and FIFO pointer/level next state.
    always_comb begin
        ready_d  = accept_s;
        rdata_d  = 32'h0000_0000;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept_s && !is_wr_s && sel_stat_s) begin
            rdata_d = status_s;
        end else begin
            rdata_d = 32'h0000_0000;
        end
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Serializer FSM; txd is registered from the value the next state will drive.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        pop_s   = 1'b0;
        txd_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    shreg_d = fifo_rdata_s;
`ifdef UART_TX_PARITY_EN
                    par_d   = parity8(fifo_rdata_s);
`endif
                    baud_d  = 16'd0;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (baud_end_s) begin
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d  = baud_q + 16'd1;
                end
            end
            S_DATA: begin
                if (baud_end_s) begin
                    baud_d = 16'd0;
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_end_s) begin
                    baud_d  = 16'd0;
                    state_d = S_STOP;
                end else begin
                    baud_d  = baud_q + 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (baud_end_s) begin
                    baud_d = 16'd0;
                    if (!empty_s) begin
                        pop_s   = 1'b1;
                        shreg_d = fifo_rdata_s;
`ifdef UART_TX_PARITY_EN
                        par_d   = parity8(fifo_rdata_s);
`endif
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = 16'd0;
                bit_d   = 3'd0;
            end
        endcase
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_d = par_d;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    // FIFO storage; contents are don't-care until pushed, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem[wr_ptr_q] <= mem_wdata[7:0];
        end
    end

    // State registers; reset aborts any frame and drops queued bytes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q  <= 1'b0;
            rdata_q  <= 32'h0000_0000;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            baud_q   <= 16'd0;
            bit_q    <= 3'd0;
            shreg_q  <= 8'h00;
            txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            txd_q    <= txd_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign txd       = txd_q;

endmodule
